ula_ctrl: RTL and testbench

Two-requester controller that shares the 8-bit `ula` datapath, which has registered inputs, a registered output, an `op` decoder, and add/sub units. It arbitrates between requesters, drives operands and opcode into the ALU and holds them stable for the ALU's register latency. It then captures the result and returns it on a buffered valid/ready response port tagged with the requester id. Only one operation is in flight at a time; unsupported opcodes are answered without touching the ALU.

---
 rtl/ula_ctrl_pkg.sv | 23 ++
 rtl/ula_rr_arbiter.sv | 46 ++++
 rtl/ula_ctrl.sv | 145 ++++++++++++++
 tb/tb_ula_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_ctrl_pkg.sv
// Shared types and constants for the ula controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ula_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;

   // Clock edges from an operand/opcode change until the ALU result reflects it.
   localparam int ULA_LAT_DEFAULT = 2;

   // Only add and sub are routed to the ALU; everything else is answered with an error.
   function automatic logic op_supported(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/ula_rr_arbiter.sv
// Two-way arbiter with a last-grant pointer that moves only on accept.
// Latency: grant is combinational from the request inputs.
// Backpressure: grants are advisory; the pointer holds until accept is high.
// Build option ULA_CTRL_FIXED_PRIO_EN: requester 0 always wins, no pointer.
module ula_rr_arbiter
(
   input  logic clk,
   input  logic rst,
   input  logic req0,
   input  logic req1,
   input  logic accept,
   output logic gnt0,
   output logic gnt1
);

`ifdef ULA_CTRL_FIXED_PRIO_EN

   // Fixed priority: requester 0 wins every contest.
   always_comb begin
      gnt0 = req0;
      gnt1 = req1 && !req0;
   end

`else

   // last_id = requester granted on the most recent accept; reset to 1 so 0 wins first.
   logic last_id;

   // On contention grant the requester that did not win last time.
   always_comb begin
      gnt0 = req0 && (!req1 || last_id);
      gnt1 = req1 && (!req0 || !last_id);
   end

   // Pointer advances only when a grant is actually taken.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_id <= 1'b1;
      end else if (accept) begin
         last_id <= gnt1;
      end
   end

`endif

endmodule

// File: rtl/ula_ctrl.sv
// Shares the registered 8-bit ula ALU between two requesters; one op in flight.
// Latency: add/sub response valid ULA_LAT+1 edges after accept; bad opcode on the accept edge.
// Backpressure: response held until rsp_ready; no requester is ready outside IDLE.
// Build option ULA_CTRL_FIXED_PRIO_EN (in ula_rr_arbiter) selects fixed priority.
module ula_ctrl
   import ula_ctrl_pkg::*;
#(
   parameter int ULA_LAT = ULA_LAT_DEFAULT
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [2:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [2:0] req1_op,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_s,
   output logic       rsp_err,
   output logic [7:0] ula_a,
   output logic [7:0] ula_b,
   output logic [2:0] ula_op,
   input  logic [7:0] ula_s
);

   localparam int CNT_W = $clog2(ULA_LAT + 2);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             gnt0;
   logic             gnt1;
   logic             accept;
   logic [7:0]       sel_a;
   logic [7:0]       sel_b;
   logic [2:0]       sel_op;

   ula_rr_arbiter u_arb (
      .clk    (clk),
      .rst    (rst),
      .req0   (req0_valid),
      .req1   (req1_valid),
      .accept (accept),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   // Ready only for the granted requester while idle; forced low during reset.
   always_comb begin
      req0_ready = (state == IDLE) && !rst && gnt0;
      req1_ready = (state == IDLE) && !rst && gnt1;
      accept     = req0_ready || req1_ready;
      sel_a      = gnt1 ? req1_a  : req0_a;
      sel_b      = gnt1 ? req1_b  : req0_b;
      sel_op     = gnt1 ? req1_op : req0_op;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: unsupported ops skip the ALU and go straight to the response.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = op_supported(sel_op) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (rsp_valid && rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ALU operand registers, latency counter and response buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ula_a     <= '0;
         ula_b     <= '0;
         ula_op    <= '0;
         cnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_s     <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  rsp_id <= gnt1;
                  if (op_supported(sel_op)) begin
                     ula_a  <= sel_a;
                     ula_b  <= sel_b;
                     ula_op <= sel_op;
                     cnt    <= CNT_W'(ULA_LAT);
                  end else begin
                     rsp_s     <= '0;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_s     <= ula_s;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               if (rsp_valid && rsp_ready) begin
                  rsp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed self-checking bench for ula_ctrl with a behavioural two-stage ALU.
// Latency: n/a.
// Backpressure: exercises held responses with rsp_ready low.
module tb_ula_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req0_a = '0;
    logic [7:0] req0_b = '0;
    logic [2:0] req0_op = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] req1_a = '0;
    logic [7:0] req1_b = '0;
    logic [2:0] req1_op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic       rsp_id;
    logic [7:0] rsp_s;
    logic       rsp_err;
    logic [7:0] ula_a;
    logic [7:0] ula_b;
    logic [2:0] ula_op;
    logic [7:0] ula_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: input registers then output register (two edges).
    logic [7:0] alu_a = '0;
    logic [7:0] alu_b = '0;
    logic [2:0] alu_op = '0;
    logic [7:0] alu_s = '0;
    always @(posedge clk) begin
        alu_a  <= ula_a;
        alu_b  <= ula_b;
        alu_op <= ula_op;
        alu_s  <= (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);
    end
    assign ula_s = alu_s;

    ula_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_err    (rsp_err),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_op     (ula_op),
        .ula_s      (ula_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Issue one op from a single requester, measure edges from accept to rsp_valid.
    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] exp_s,
                          input logic exp_err, input int exp_lat);
        logic got;
        int   lat;
        if (id) begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            if (got) break;
        end
        chk("accept_seen", got, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        chk("rsp_seen", got, 1'b1);
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_id", rsp_id, id);
        chk("rsp_s", rsp_s, exp_s);
        chk("rsp_err", rsp_err, exp_err);
        @(posedge clk);
        #1;
        chk("rsp_cleared", rsp_valid, 1'b0);
    endtask

    initial begin
        logic       got;
        logic       saw;
        logic [2:0] op_before;
        logic [7:0] a_before;
        logic       exp_id[4];

        // Reset state, with a requester pushing during reset.
        req0_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_s", rsp_s, 8'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_ula_a", ula_a, 8'h00);
        chk("rst_ula_b", ula_b, 8'h00);
        chk("rst_ula_op", ula_op, 3'b000);
        req0_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add and sub, then an unsupported opcode, then add with wrap.
        run_op(1'b0, 8'h05, 8'h03, 3'b000, 8'h08, 1'b0, 3);
        run_op(1'b1, 8'h03, 8'h05, 3'b001, 8'hFE, 1'b0, 3);
        op_before = ula_op;
        a_before  = ula_a;
        run_op(1'b0, 8'h12, 8'h34, 3'b101, 8'h00, 1'b1, 0);
        chk("bad_op_ula_op_kept", ula_op, 3'b001);
        chk("bad_op_ula_op_same", ula_op, op_before);
        chk("bad_op_ula_a_kept", ula_a, a_before);
        run_op(1'b0, 8'hFF, 8'h02, 3'b000, 8'h01, 1'b0, 3);

        // Backpressure: response held while rsp_ready is low, requester 1 waiting.
        rsp_ready = 1'b0;
        req0_a = 8'h20; req0_b = 8'h07; req0_op = 3'b001; req0_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got = req0_ready;
            if (got) break;
        end
        chk("bp_accept_seen", got, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_a = 8'h01; req1_b = 8'h01; req1_op = 3'b000; req1_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got = rsp_valid;
            if (got) break;
        end
        chk("bp_rsp_seen", got, 1'b1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_s", rsp_s, 8'h19);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_err", rsp_err, 1'b0);
            chk("bp_req0_ready", req0_ready, 1'b0);
            chk("bp_req1_ready", req1_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_hs_clear", rsp_valid, 1'b0);
        chk("bp_idle_req1_ready", req1_ready, 1'b1);
        req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Contention: reset pointer, then both requesters valid for four ops.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
`ifdef ULA_CTRL_FIXED_PRIO_EN
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        req0_a = 8'h01; req0_b = 8'h01; req0_op = 3'b000;
        req1_a = 8'h10; req1_b = 8'h03; req1_op = 3'b001;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                got = rsp_valid;
                if (got) break;
            end
            chk("rr_rsp_seen", got, 1'b1);
            chk("rr_id", rsp_id, exp_id[i]);
            chk("rr_s", rsp_s, exp_id[i] ? 8'h0D : 8'h02);
            @(posedge clk);
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset during WAIT drops the operation.
        req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'b001; req0_valid = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            got = req0_ready;
            if (got) break;
        end
        chk("mid_accept_seen", got, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_ula_a_loaded", ula_a, 8'h11);
        rst = 1'b1;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_ula_a", ula_a, 8'h00);
        chk("mid_rst_ula_b", ula_b, 8'h00);
        chk("mid_rst_ula_op", ula_op, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        saw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            saw = saw | rsp_valid;
        end
        chk("mid_no_rsp", saw, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
